// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam int IF  = 0;
  localparam int ID  = 1;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int WB  = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low reset
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers and PC
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mul_start,
  input  logic                  ex_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  input  logic                  wb_ebreak,
  output logic                  en_pc,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  en_exmem,
  output logic                  en_memwb,
  output logic                  clr_ifid,
  output logic                  clr_idex,
  output logic                  clr_exmem,
  output logic                  mul_done,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [3:0] MUL_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_e       r_state;
  state_e       w_state_nxt;
  logic [3:0]   r_mul_cnt;
  logic [3:0]   w_mul_cnt_nxt;
  logic [WB:IF] w_en;
  logic [MEM:ID] w_clr;
  logic         w_mul_done;
  logic         w_mfreeze;
  logic         w_lu;
  logic         w_stall_inc;

  assign w_mfreeze = dmem_req & ~dmem_ack;
  assign w_lu = ex_is_load & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_mul_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Fixed priority: halt, memory freeze, multi-cycle EX, redirect, load-use.
  always_comb begin
    w_en          = '1;
    w_clr         = '0;
    w_mul_done    = 1'b0;
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    if (!reset) begin
      w_en  = '0;
      w_clr = '1;
    end else if (r_state == ST_HALT) begin
      w_en = '0;
    end else if (w_mfreeze) begin
      w_en = '0;
    end else if (r_state == ST_MUL_WAIT) begin
      if (r_mul_cnt != 4'd0) begin
        w_en[IF]      = 1'b0;
        w_en[ID]      = 1'b0;
        w_en[EX]      = 1'b0;
        w_clr[MEM]    = 1'b1;
        w_mul_cnt_nxt = r_mul_cnt - 4'd1;
      end else begin
        w_mul_done  = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end else if (ex_mul_start && (MUL_LAT > 1)) begin
      w_en[IF]      = 1'b0;
      w_en[ID]      = 1'b0;
      w_en[EX]      = 1'b0;
      w_clr[MEM]    = 1'b1;
      w_mul_cnt_nxt = MUL_LOAD;
      w_state_nxt   = ST_MUL_WAIT;
    end else begin
      // Only reachable with ex_mul_start set when the op is single-cycle.
      w_mul_done = ex_mul_start;
      if (ex_redirect) begin
        w_clr[ID] = 1'b1;
        w_clr[EX] = 1'b1;
      end else if (w_lu) begin
        w_en[IF]  = 1'b0;
        w_en[ID]  = 1'b0;
        w_clr[EX] = 1'b1;
      end
    end
    if (reset && (r_state != ST_HALT) && !w_mfreeze && wb_ebreak) begin
      w_state_nxt = ST_HALT;
    end
  end

  assign w_stall_inc = (r_state != ST_HALT) & ~w_en[IF];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .value (stall_cycles)
  );

  assign en_pc     = w_en[IF];
  assign en_ifid   = w_en[ID];
  assign en_idex   = w_en[EX];
  assign en_exmem  = w_en[MEM];
  assign en_memwb  = w_en[WB];
  assign clr_ifid  = w_clr[ID];
  assign clr_idex  = w_clr[EX];
  assign clr_exmem = w_clr[MEM];
  assign mul_done  = w_mul_done;
  assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0;
  logic          ex_mul_start = 0, ex_redirect = 0, dmem_req = 0, dmem_ack = 0, wb_ebreak = 0;
  logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic          clr_ifid, clr_idex, clr_exmem, mul_done, halted;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: halted flag, EX cycles still owed to the current multi-cycle op, stall count.
  bit m_halted = 0;
  int m_left   = 0;
  int m_stalls = 0;

  pipe_hazard_ctrl #(.MUL_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mul_start(ex_mul_start),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .wb_ebreak(wb_ebreak),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .clr_ifid(clr_ifid), .clr_idex(clr_idex), .clr_exmem(clr_exmem),
    .mul_done(mul_done), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Expected {en_pc,en_ifid,en_idex,en_exmem,en_memwb,clr_ifid,clr_idex,clr_exmem,mul_done,halted}.
  function automatic logic [9:0] model_eval();
    logic [4:0] en;
    logic [2:0] clr;
    logic done, freeze, lu;
    en = 5'b11111; clr = 3'b000; done = 0;
    freeze = dmem_req && !dmem_ack;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!reset) return {5'b00000, 3'b111, 1'b0, 1'b0};
    if (m_halted) return {5'b00000, 3'b000, 1'b0, 1'b1};
    if (freeze) return {5'b00000, 3'b000, 1'b0, 1'b0};
    if (m_left == 1) return {5'b11111, 3'b000, 1'b1, 1'b0};
    if (m_left > 1 || (ex_mul_start && LAT > 1)) return {5'b00011, 3'b001, 1'b0, 1'b0};
    if (ex_mul_start) done = 1;
    if (ex_redirect) clr = 3'b110;
    else if (lu) begin en = 5'b00111; clr = 3'b010; end
    return {en, clr, done, 1'b0};
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [9:0] e;
    if (!reset) begin
      m_halted = 0; m_left = 0; m_stalls = 0;
    end else begin
      e = model_eval();
      if (!m_halted && !e[9] && m_stalls < SAT) m_stalls++;
      if (!m_halted && !(dmem_req && !dmem_ack)) begin
        if (m_left > 0) m_left--;
        else if (ex_mul_start && LAT > 1) m_left = LAT - 1;
        if (wb_ebreak) begin m_halted = 1; m_left = 0; end
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e, a;
    e = model_eval();
    a = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, clr_ifid, clr_idex, clr_exmem, mul_done, halted};
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL outputs t=%0t got %b expected %b", $time, a, e);
    end
    n_checks++;
    if (int'(stall_cycles) != m_stalls) begin
      n_errors++;
      $display("FAIL stall_cycles t=%0t got %0d expected %0d", $time, stall_cycles, m_stalls);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    ex_mul_start = 0; ex_redirect = 0; dmem_req = 0; dmem_ack = 0; wb_ebreak = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    next_cyc();
    reset = 1;
    clear_inputs();
  endtask

  initial begin
    int stalls, done_at;
    clear_inputs();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_en_pc", en_pc, 0);
      chk("reset_clr_idex", clr_idex, 1);
      next_cyc();
    end
    reset = 1;
    @(negedge clk);
    chk("idle_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 31);
    chk("idle_clr", {clr_ifid, clr_idex, clr_exmem}, 0);
    chk("idle_stalls", stall_cycles, 0);
    next_cyc();

    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_en_pc", en_pc, 0);
    chk("lu_clr_idex", clr_idex, 1);
    next_cyc();
    clear_inputs();
    @(negedge clk);
    chk("lu_released", en_pc, 1);
    chk("lu_stalls", stall_cycles, 1);
    next_cyc();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_x0_no_stall", en_pc, 1);
    next_cyc();

    do_reset();
    stalls = 0; done_at = 0;
    ex_mul_start = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (!en_pc) stalls++;
      if (mul_done && done_at == 0) done_at = c;
      next_cyc();
      ex_mul_start = 0;
    end
    chk("mul_stall_cycles", stalls, 3);
    chk("mul_done_cycle", done_at, 4);
    chk("mul_stall_count", stall_cycles, 3);

    do_reset();
    stalls = 0; done_at = 0;
    ex_mul_start = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (!en_pc) stalls++;
      if (mul_done && done_at == 0) done_at = c;
      if (c == 2) chk("freeze_en_all", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 0);
      next_cyc();
      ex_mul_start = 0;
      dmem_req = (c == 1 || c == 2);
      dmem_ack = 0;
    end
    chk("freeze_done_cycle", done_at, 6);
    chk("freeze_stall_count", stall_cycles, 5);

    do_reset();
    ex_redirect = 1; ex_is_load = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
    @(negedge clk);
    chk("redir_clr", {clr_ifid, clr_idex}, 3);
    chk("redir_en_pc", en_pc, 1);
    next_cyc();
    clear_inputs();
    wb_ebreak = 1;
    next_cyc();
    wb_ebreak = 0;
    ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    @(negedge clk);
    chk("halt_flag", halted, 1);
    chk("halt_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 0);
    next_cyc();
    @(negedge clk);
    chk("halt_stalls_frozen", stall_cycles, 0);
    #1 reset = 0;
    #1 chk("async_reset_halted", halted, 0);
    chk("async_reset_clr", clr_ifid, 1);
    next_cyc();
    reset = 1;
    clear_inputs();

    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    repeat (20) next_cyc();
    clear_inputs();
    @(negedge clk);
    chk("stall_saturation", stall_cycles, SAT);
    next_cyc();

    for (int i = 0; i < 1500; i++) begin
      if (m_halted || $urandom_range(0, 99) == 0) begin
        do_reset();
      end
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_is_load   = ($urandom_range(0, 2) == 0);
      ex_mul_start = ($urandom_range(0, 5) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ack     = 1'($urandom_range(0, 1));
      wb_ebreak    = ($urandom_range(0, 59) == 0);
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
